// File: rtl/switch_press_decoder.sv
// switch_press_decoder
//   Classifies presses of a debounced, already-synchronous switch level into
//   short, long and (optionally) double presses.
//   Each press kind is reported as a registered one-cycle pulse.
//
//   Build option: define SWITCH_PRESS_DOUBLE_EN to enable double-press
//   detection (GAP / HELD2 states and o_Double_Pulse). When the macro is left
//   undefined, a short press is reported on the cycle after its release edge
//   and o_Double_Pulse is tied low.
//
//   LONG_CYCLES : hold length in clocks that makes a press long
//   GAP_CYCLES  : longest release-to-press gap in clocks that still forms a
//                 double press
//   CNT_WIDTH   : shared counter width; 2**CNT_WIDTH must exceed both limits

module switch_press_decoder #(
  parameter int LONG_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 6250000,
  parameter int CNT_WIDTH   = 24
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Short_Pulse,
  output logic o_Long_Pulse,
  output logic o_Double_Pulse,
  output logic o_Busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD      = 3'd1,
    LONG_WAIT = 3'd2,
    GAP       = 3'd3,
    HELD2     = 3'd4
  } state_t;

  // The counter must be able to reach the larger of the two limits.
  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;

  if ((longint'(1) << CNT_WIDTH) <= longint'(MAX_CYCLES)) begin : g_bad_cnt_width
    $error("switch_press_decoder: CNT_WIDTH too small for LONG_CYCLES/GAP_CYCLES");
  end

  // Terminal counts: the counter reads N-1 on the Nth cycle spent in a state.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
`ifdef SWITCH_PRESS_DOUBLE_EN
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_CYCLES - 1);
`endif

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   count;
  logic                   r_Switch;
  logic                   w_press_edge;
  logic                   w_release_edge;

  logic                   short_nxt;
  logic                   long_nxt;
  logic                   r_short;
  logic                   r_long;
  logic                   r_busy;
`ifdef SWITCH_PRESS_DOUBLE_EN
  logic                   double_nxt;
  logic                   r_double;
`endif

  // Edges compare the live level against last cycle's registered level.
  assign w_press_edge   =  i_Switch & ~r_Switch;
  assign w_release_edge = ~i_Switch &  r_Switch;

  // State register, shared hold/gap counter and previous switch level.
  // NOTE: r_Switch resets to 1 so a switch already held when reset lifts is
  // not mistaken for a fresh press; only its later release is seen (and
  // ignored in IDLE).
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      count    <= '0;
      r_Switch <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its peers, independent of statement order.
      state    <= state_nxt;
      r_Switch <= i_Switch;
      if (state_nxt != state) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state decode; release beats the long timeout and press beats the
  // gap timeout when both land in the same cycle.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (w_press_edge) begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (w_release_edge) begin
`ifdef SWITCH_PRESS_DOUBLE_EN
          state_nxt = GAP;
`else
          state_nxt = IDLE;
`endif
        end else if (count == LONG_LAST) begin
          state_nxt = LONG_WAIT;
        end
      end
      LONG_WAIT: begin
        if (w_release_edge) begin
          state_nxt = IDLE;
        end
      end
`ifdef SWITCH_PRESS_DOUBLE_EN
      GAP: begin
        if (w_press_edge) begin
          state_nxt = HELD2;
        end else if (count == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      HELD2: begin
        if (w_release_edge) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pulse decode: which classification fires on this edge, if any. Each
  // condition belongs to exactly one state, so at most one pulse is set.
  always_comb begin
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
`ifdef SWITCH_PRESS_DOUBLE_EN
    double_nxt = 1'b0;
`endif
    unique case (state)
      HELD: begin
`ifdef SWITCH_PRESS_DOUBLE_EN
        long_nxt  = ~w_release_edge & (count == LONG_LAST);
`else
        short_nxt = w_release_edge;
        long_nxt  = ~w_release_edge & (count == LONG_LAST);
`endif
      end
`ifdef SWITCH_PRESS_DOUBLE_EN
      GAP: begin
        short_nxt = ~w_press_edge & (count == GAP_LAST);
      end
      HELD2: begin
        double_nxt = w_release_edge;
      end
`endif
      default: begin
        short_nxt = 1'b0;
      end
    endcase
  end

  // Registered pulses and busy flag, updated on the same edge as the state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_busy   <= 1'b0;
`ifdef SWITCH_PRESS_DOUBLE_EN
      r_double <= 1'b0;
`endif
    end else begin
      r_short  <= short_nxt;
      r_long   <= long_nxt;
      r_busy   <= (state_nxt != IDLE);
`ifdef SWITCH_PRESS_DOUBLE_EN
      r_double <= double_nxt;
`endif
    end
  end

  assign o_Short_Pulse  = r_short;
  assign o_Long_Pulse   = r_long;
  assign o_Busy         = r_busy;
`ifdef SWITCH_PRESS_DOUBLE_EN
  assign o_Double_Pulse = r_double;
`else
  assign o_Double_Pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_press_decoder.sv
// tb_switch_press_decoder
//   Directed vectors for switch_press_decoder with LONG_CYCLES=8,
//   GAP_CYCLES=4, CNT_WIDTH=4. Expected pulse cycles are hand-computed for
//   both builds (SWITCH_PRESS_DOUBLE_EN defined or not).
//   Step k drives i_Switch, waits for rising edge Ek, then samples 1 ns later;
//   a pulse caused by the condition at Ek is expected at sample k.

module tb_switch_press_decoder;

  logic i_Clk;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Short_Pulse;
  logic o_Long_Pulse;
  logic o_Double_Pulse;
  logic o_Busy;

  int n_vec  = 0;
  int n_miss = 0;

  switch_press_decoder #(
    .LONG_CYCLES (8),
    .GAP_CYCLES  (4),
    .CNT_WIDTH   (4)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Switch       (i_Switch),
    .o_Short_Pulse  (o_Short_Pulse),
    .o_Long_Pulse   (o_Long_Pulse),
    .o_Double_Pulse (o_Double_Pulse),
    .o_Busy         (o_Busy)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pulses();
    return {5'b0, o_Short_Pulse, o_Long_Pulse, o_Double_Pulse};
  endfunction

  // Apply pattern bit k as i_Switch on step k; check the pulse vector every
  // step, busy after the first step, and busy low at the end.
  task automatic run_vec(input string tag, input logic [31:0] pat, input int n,
                         input logic busy0, input int s1, input int s2,
                         input int l, input int d);
    logic [7:0] exp;
    for (int k = 0; k < n; k++) begin
      i_Switch = pat[k];
      @(posedge i_Clk);
      #1;
      exp = {5'b0, (k == s1) || (k == s2), (k == l), (k == d)};
      check($sformatf("%s.pulse[%0d]", tag, k), pulses(), exp);
      if (k == 0) check($sformatf("%s.busy0", tag), {7'b0, o_Busy}, {7'b0, busy0});
    end
    check($sformatf("%s.busy_end", tag), {7'b0, o_Busy}, 8'h00);
  endtask

  initial begin
    i_Rst_L  = 1'b0;
    i_Switch = 1'b1;

    // Reset: everything low, switch held throughout.
    #23;
    check("rst.pulses", pulses(), 8'h00);
    check("rst.busy", {7'b0, o_Busy}, 8'h00);
    @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;

    // Switch held across reset release: no press, its release is ignored.
    run_vec("held_at_rst", 32'h0000_0007, 10, 1'b0, -1, -1, -1, -1);

`ifdef SWITCH_PRESS_DOUBLE_EN
    run_vec("short3",    32'h0000_0007, 12, 1'b1,  7, -1, -1, -1);
    run_vec("long20",    32'h000F_FFFF, 26, 1'b1, -1, -1,  8, -1);
    run_vec("rel_at_7",  32'h0000_00FF, 14, 1'b1, 12, -1, -1, -1);
    run_vec("hold_9",    32'h0000_01FF, 14, 1'b1, -1, -1,  8, -1);
    run_vec("double",    32'h0000_0033, 12, 1'b1, -1, -1, -1,  6);
    run_vec("press_tmo", 32'h0000_00C3, 14, 1'b1, -1, -1, -1,  8);
    run_vec("gap_late",  32'h0000_0183, 16, 1'b1,  6, 13, -1, -1);
`else
    run_vec("short3",    32'h0000_0007, 12, 1'b1,  3, -1, -1, -1);
    run_vec("long20",    32'h000F_FFFF, 26, 1'b1, -1, -1,  8, -1);
    run_vec("rel_at_7",  32'h0000_00FF, 14, 1'b1,  8, -1, -1, -1);
    run_vec("hold_9",    32'h0000_01FF, 14, 1'b1, -1, -1,  8, -1);
    run_vec("double",    32'h0000_0033, 12, 1'b1,  2,  6, -1, -1);
    run_vec("press_tmo", 32'h0000_00C3, 14, 1'b1,  2,  8, -1, -1);
    run_vec("gap_late",  32'h0000_0183, 16, 1'b1,  2,  9, -1, -1);
`endif

    // Reset in the middle of a hold: press discarded, nothing reported.
    for (int k = 0; k < 5; k++) begin
      i_Switch = 1'b1;
      @(posedge i_Clk);
      #1;
    end
    check("mid.busy_held", {7'b0, o_Busy}, 8'h01);
    check("mid.pulses_held", pulses(), 8'h00);
    #2;
    i_Rst_L = 1'b0;
    #1;
    check("mid.busy_async", {7'b0, o_Busy}, 8'h00);
    check("mid.pulses_async", pulses(), 8'h00);
    @(posedge i_Clk);
    @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    run_vec("rst_mid", 32'h0000_0003, 10, 1'b0, -1, -1, -1, -1);

    // Normal operation resumes after reset.
`ifdef SWITCH_PRESS_DOUBLE_EN
    run_vec("post_rst", 32'h0000_0007, 12, 1'b1, 7, -1, -1, -1);
`else
    run_vec("post_rst", 32'h0000_0007, 12, 1'b1, 3, -1, -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
